xgmii_frame_gen: RTL and testbench
==================================

XGMII_FRAME_GEN -- requirements
Module: xgmii_frame_gen

Interface
REQ-001 SHALL have parameter VLD_DIV, default 2, meaning valid-slot spacing in clocks; legal values are 1 (every cycle) and 2 (every other cycle).
REQ-002 SHALL have parameter LEN_W, default 16, meaning the width of the payload length field.
REQ-003 SHALL have parameter MIN_LEN, default 46, meaning the minimum payload bytes.
REQ-004 SHALL have parameter MAX_LEN, default 9600, meaning the maximum payload bytes.
REQ-005 SHALL have port tx_user_clk_i, input, 1 bit: the single clock.
REQ-006 SHALL have port tx_user_rst_i, input, 1 bit: reset, asynchronous, active-high.
REQ-007 SHALL have port start_i, input, 1 bit: begin a burst; sampled only in IDLE.
REQ-008 SHALL have port stop_i, input, 1 bit: end the burst after the current frame.
REQ-009 SHALL have port frame_len_i, input, LEN_W bits: payload bytes per frame, excluding preamble and SFD.
REQ-010 SHALL have port ipg_i, input, 8 bits: idle words between frames.
REQ-011 SHALL have port frame_cnt_i, input, 16 bits: frames per burst; 0 means continuous.
REQ-012 SHALL have port xgmii_txd_o, output, 64 bits: lane0 = bits[7:0], transmitted first.
REQ-013 SHALL have port xgmii_txc_o, output, 8 bits: per-lane control flags.
REQ-014 SHALL have port xgmii_txd_vld_o, output, 1 bit: txd/txc valid strobe.
REQ-015 SHALL have port busy_o, output, 1 bit: burst in progress.
REQ-016 SHALL have port done_o, output, 1 bit: one-clock pulse at burst end.
REQ-017 SHALL have port frames_sent_o, output, 32 bits: frames completed since reset; wraps modulo 2^32.

Function
REQ-018 All outputs SHALL be registered; txd/txc SHALL change only on cycles where xgmii_txd_vld_o=1 and SHALL hold otherwise.
REQ-019 For VLD_DIV=2, vld SHALL alternate 0,1,0,1... starting 0 on the first clock after reset release; for VLD_DIV=1, vld SHALL be 1 on every clock after reset release.
REQ-020 FSM states SHALL be IDLE, START, DATA, TERM, IPG; transitions SHALL occur only on valid slots, except IDLE->START, which SHALL occur on the clock edge that samples start_i=1 in IDLE.
REQ-021 On start in IDLE, the block SHALL latch len=clamp(frame_len_i,MIN_LEN,MAX_LEN), ipg=max(ipg_i,1), cnt=frame_cnt_i; busy_o SHALL be 1 on the next cycle.
REQ-022 start_i asserted while busy_o=1 SHALL be ignored, and config changes mid-burst SHALL have no effect.
REQ-023 IDLE/IPG words SHALL be txd=64'h0707070707070707, txc=8'hFF.
REQ-024 The START word SHALL be txd=64'hD5555555555555FB, txc=8'h01, and SHALL be emitted on the first valid slot after entering START.
REQ-025 Payload byte k (0-based) of frame n (0-based within the burst) SHALL equal (n[7:0]+k) mod 256.
REQ-026 DATA SHALL emit floor(len/8) full words with txc=8'h00.
REQ-027 The TERM word SHALL carry the remaining r=len mod 8 payload bytes in lanes 0..r-1, FD in lane r, and 07 in lanes r+1..7; txc SHALL have bits r..7 set; r=0 SHALL give txd=64'h07070707070707FD, txc=8'hFF.
REQ-028 After TERM, frames_sent_o SHALL increment by 1 and the FSM SHALL emit exactly ipg IPG words.
REQ-029 After IPG, the FSM SHALL go to START if (cnt==0 or frames-in-burst<cnt) and no stop is pending; otherwise it SHALL go to IDLE.
REQ-030 stop_i SHALL be latched as stop-pending at any time while busy and cleared on entering IDLE; a frame in progress SHALL always complete, including its IPG.
REQ-031 On the IPG->IDLE transition, done_o SHALL pulse for one clock and busy_o SHALL fall on the same cycle.
REQ-032 A simultaneous start_i and stop_i in IDLE SHALL start the burst and send exactly one frame.
REQ-033 The per-burst frame index n SHALL reset to 0 at each start.

Reset
REQ-034 Asserting tx_user_rst_i SHALL immediately force: state IDLE, txd=64'h0707070707070707, txc=8'hFF, vld=0, busy_o=0, done_o=0, frames_sent_o=0, stop-pending=0.
REQ-035 Reset mid-frame SHALL abort the frame with no TERM word and SHALL leave frames_sent_o=0.

Verification
REQ-036 VLD_DIV=2, len=64, ipg=1, cnt=1: the bench SHALL expect START, 8 DATA words (bytes 00..3F), TERM=64'h07070707070707FD/txc FF, 1 idle word, then done_o pulse and frames_sent_o=1.
REQ-037 len=61, cnt=2: the bench SHALL expect the TERM word of frame 0 to be bytes 38,39,3A,3B,3C, FD, 07, 07 with txc=8'hE0, and frame 1 payload to start at 01.
REQ-038 frame_len_i=10: the bench SHALL expect a clamp to 46 (5 DATA words, r=6, txc=8'hC0); frame_len_i=20000 SHALL clamp to 9600.
REQ-039 cnt=0 with stop_i pulsed during DATA of frame 3: the bench SHALL expect frame 3 to complete, its IPG to be sent, IDLE to follow, and frames_sent_o=4.
REQ-040 ipg_i=0, cnt=3: the bench SHALL expect exactly 1 idle word between frames; start_i pulsed mid-burst SHALL have no effect.
REQ-041 Reset asserted during DATA: the bench SHALL expect outputs to go to idle/zero within the same cycle and no FD to be emitted.

Source files
------------

// File: rtl/xgmii_frame_gen.sv
// XGMII test-frame burst generator: emits START / incrementing-payload DATA / TERM / IPG
// words on a 64-bit XGMII bus, with the valid strobe running at one slot every VLD_DIV clocks.
module xgmii_frame_gen #(
  parameter int VLD_DIV = 2,
  parameter int LEN_W   = 16,
  parameter int MIN_LEN = 46,
  parameter int MAX_LEN = 9600
) (
  input  logic             tx_user_clk_i,
  input  logic             tx_user_rst_i,
  input  logic             start_i,
  input  logic             stop_i,
  input  logic [LEN_W-1:0] frame_len_i,
  input  logic [7:0]       ipg_i,
  input  logic [15:0]      frame_cnt_i,
  output logic [63:0]      xgmii_txd_o,
  output logic [7:0]       xgmii_txc_o,
  output logic             xgmii_txd_vld_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [31:0]      frames_sent_o
);

  localparam logic [63:0] IDLE_WORD  = 64'h0707070707070707;
  localparam logic [63:0] START_WORD = 64'hD5555555555555FB;
  localparam int          WCNT_W     = LEN_W - 3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_TERM  = 3'd3,
    ST_IPG   = 3'd4
  } state_t;

  state_t            state_r;
  logic              vld_r;
  logic [63:0]       txd_r;
  logic [7:0]        txc_r;
  logic              busy_r;
  logic              done_r;
  logic [31:0]       frames_sent_r;
  logic              stop_pend_r;
  logic [LEN_W-1:0]  len_r;
  logic [7:0]        ipg_r;
  logic [7:0]        ipg_left_r;
  logic [15:0]       cnt_r;
  logic [15:0]       frame_idx_r;
  logic [WCNT_W-1:0] words_left_r;
  logic [7:0]        byte_base_r;

  logic              slot_s;
  logic [LEN_W-1:0]  len_clamp_s;
  logic [2:0]        rem_s;
  logic [63:0]       data_word_s;
  logic [63:0]       term_word_s;
  logic [7:0]        term_ctl_s;
  logic              more_s;

  // Next-cycle valid strobe: a slot is any edge at which vld will be 1
  always_comb begin
    if (VLD_DIV == 1) begin
      slot_s = 1'b1;
    end else begin
      slot_s = ~vld_r;
    end
  end

  // Payload length clamp applied when a burst is launched
  always_comb begin
    if (frame_len_i < LEN_W'(MIN_LEN)) begin
      len_clamp_s = LEN_W'(MIN_LEN);
    end else if (frame_len_i > LEN_W'(MAX_LEN)) begin
      len_clamp_s = LEN_W'(MAX_LEN);
    end else begin
      len_clamp_s = frame_len_i;
    end
  end

  // Payload and TERM word assembly; lane i of a word carries byte base+i
  always_comb begin
    rem_s       = len_r[2:0];
    data_word_s = 64'd0;
    term_word_s = 64'd0;
    term_ctl_s  = 8'd0;
    for (int i = 0; i < 8; i++) begin
      data_word_s[8*i +: 8] = byte_base_r + 8'(i);
      term_ctl_s[i]         = (i >= int'(rem_s));
      if (i < int'(rem_s)) begin
        term_word_s[8*i +: 8] = byte_base_r + 8'(i);
      end else if (i == int'(rem_s)) begin
        term_word_s[8*i +: 8] = 8'hFD;
      end else begin
        term_word_s[8*i +: 8] = 8'h07;
      end
    end
  end

  // frame_idx_r has already counted the frame just terminated
  always_comb begin
    if (stop_pend_r) begin
      more_s = 1'b0;
    end else begin
      more_s = (cnt_r == 16'd0) || (frame_idx_r < cnt_r);
    end
  end

  // Burst FSM, slot strobe and all registered outputs
  always_ff @(posedge tx_user_clk_i or posedge tx_user_rst_i) begin
    if (tx_user_rst_i) begin
      state_r       <= ST_IDLE;
      vld_r         <= 1'b0;
      txd_r         <= IDLE_WORD;
      txc_r         <= 8'hFF;
      busy_r        <= 1'b0;
      done_r        <= 1'b0;
      frames_sent_r <= 32'd0;
      stop_pend_r   <= 1'b0;
      len_r         <= LEN_W'(MIN_LEN);
      ipg_r         <= 8'd1;
      ipg_left_r    <= 8'd1;
      cnt_r         <= 16'd0;
      frame_idx_r   <= 16'd0;
      words_left_r  <= WCNT_W'(0);
      byte_base_r   <= 8'd0;
    end else begin
      vld_r  <= slot_s;
      done_r <= 1'b0;
      if (busy_r && stop_i) begin
        stop_pend_r <= 1'b1;
      end
      // Launch is not slot-aligned; the START word waits for the next slot
      if ((state_r == ST_IDLE) && start_i) begin
        state_r     <= ST_START;
        busy_r      <= 1'b1;
        stop_pend_r <= stop_i;
        len_r       <= len_clamp_s;
        ipg_r       <= (ipg_i == 8'd0) ? 8'd1 : ipg_i;
        cnt_r       <= frame_cnt_i;
        frame_idx_r <= 16'd0;
      end
      if (slot_s) begin
        case (state_r)
          ST_IDLE: begin
            txd_r <= IDLE_WORD;
            txc_r <= 8'hFF;
          end
          ST_START: begin
            txd_r        <= START_WORD;
            txc_r        <= 8'h01;
            words_left_r <= len_r[LEN_W-1:3];
            byte_base_r  <= frame_idx_r[7:0];
            state_r      <= ST_DATA;
          end
          ST_DATA: begin
            txd_r        <= data_word_s;
            txc_r        <= 8'h00;
            byte_base_r  <= byte_base_r + 8'd8;
            words_left_r <= words_left_r - WCNT_W'(1);
            if (words_left_r == WCNT_W'(1)) begin
              state_r <= ST_TERM;
            end
          end
          ST_TERM: begin
            txd_r         <= term_word_s;
            txc_r         <= term_ctl_s;
            frames_sent_r <= frames_sent_r + 32'd1;
            frame_idx_r   <= frame_idx_r + 16'd1;
            ipg_left_r    <= ipg_r;
            state_r       <= ST_IPG;
          end
          ST_IPG: begin
            txd_r <= IDLE_WORD;
            txc_r <= 8'hFF;
            if (ipg_left_r == 8'd1) begin
              if (more_s) begin
                state_r <= ST_START;
              end else begin
                state_r     <= ST_IDLE;
                busy_r      <= 1'b0;
                done_r      <= 1'b1;
                stop_pend_r <= 1'b0;
              end
            end else begin
              ipg_left_r <= ipg_left_r - 8'd1;
            end
          end
          default: begin
            state_r <= ST_IDLE;
            txd_r   <= IDLE_WORD;
            txc_r   <= 8'hFF;
          end
        endcase
      end
    end
  end

  assign xgmii_txd_o     = txd_r;
  assign xgmii_txc_o     = txc_r;
  assign xgmii_txd_vld_o = vld_r;
  assign busy_o          = busy_r;
  assign done_o          = done_r;
  assign frames_sent_o   = frames_sent_r;

endmodule

// File: tb/tb_xgmii_frame_gen.sv
// Self-checking bench for xgmii_frame_gen: captured word stream is compared against a
// byte-level model of each burst (preamble, payload, FD, padding, inter-packet gap).
`timescale 1ns/1ps
module tb_xgmii_frame_gen;

  localparam logic [63:0] IDLE_W  = 64'h0707070707070707;
  localparam logic [63:0] START_W = 64'hD5555555555555FB;
  localparam logic [71:0] IDLE_WC = {8'hFF, 64'h0707070707070707};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [15:0] frame_len = 16'd64;
  logic [7:0]  ipg = 8'd1;
  logic [15:0] frame_cnt = 16'd1;
  logic [63:0] txd;
  logic [7:0]  txc;
  logic        vld;
  logic        busy;
  logic        done;
  logic [31:0] frames_sent;

  int tests_run = 0;
  int tests_failed = 0;
  int exp_sent = 0;

  always #5 clk = ~clk;

  xgmii_frame_gen dut (
    .tx_user_clk_i   (clk),
    .tx_user_rst_i   (rst),
    .start_i         (start),
    .stop_i          (stop),
    .frame_len_i     (frame_len),
    .ipg_i           (ipg),
    .frame_cnt_i     (frame_cnt),
    .xgmii_txd_o     (txd),
    .xgmii_txc_o     (txc),
    .xgmii_txd_vld_o (vld),
    .busy_o          (busy),
    .done_o          (done),
    .frames_sent_o   (frames_sent)
  );

  // Monitor state (written only by the monitor block)
  int          arm_req = 0;
  int          arm_seen = 0;
  logic        mon_active = 1'b0;
  logic [71:0] cap_q[$];
  int          starts_seen = 0;
  logic        done_seen = 1'b0;
  logic        done_busy = 1'b0;
  int          done_total = 0;
  logic [7:0]  last_txc = 8'hFF;
  int          vld_err = 0;
  int          hold_err = 0;
  logic        have_prev = 1'b0;
  logic        prev_vld = 1'b0;
  logic [63:0] prev_txd = 64'd0;
  logic [7:0]  prev_txc = 8'd0;

  logic [71:0] exp_q[$];
  logic [71:0] mm_act;
  logic [71:0] mm_exp;
  int          cap_off;

  // Samples on the falling edge: strobe cadence, hold behaviour and the captured stream
  always @(negedge clk) begin
    if (rst) begin
      have_prev <= 1'b0;
    end else begin
      have_prev <= 1'b1;
      prev_vld  <= vld;
      prev_txd  <= txd;
      prev_txc  <= txc;
      if (have_prev && (vld == prev_vld)) vld_err <= vld_err + 1;
      if (have_prev && !vld && ((txd !== prev_txd) || (txc !== prev_txc))) hold_err <= hold_err + 1;
      if (done) done_total <= done_total + 1;
    end
    if (arm_req != arm_seen) begin
      arm_seen    <= arm_req;
      cap_q.delete();
      mon_active  <= 1'b1;
      starts_seen <= 0;
      done_seen   <= 1'b0;
      last_txc    <= 8'hFF;
    end else if (mon_active && !rst) begin
      if (vld) begin
        cap_q.push_back({txc, txd});
        last_txc <= txc;
        if ((txd == START_W) && (txc == 8'h01)) starts_seen <= starts_seen + 1;
      end
      if (done) begin
        done_seen  <= 1'b1;
        done_busy  <= busy;
        mon_active <= 1'b0;
      end
    end
  end

  // Byte-level reference: lay out every lane of the burst, then cut it into 8-byte words
  function automatic void build_expected(input int len_raw, input int ipg_raw, input int nframes);
    int          len;
    int          gap;
    logic [7:0]  b[$];
    logic        c[$];
    logic [71:0] w;
    len = (len_raw < 46) ? 46 : ((len_raw > 9600) ? 9600 : len_raw);
    gap = (ipg_raw == 0) ? 1 : ipg_raw;
    exp_q.delete();
    for (int n = 0; n < nframes; n++) begin
      b.push_back(8'hFB); c.push_back(1'b1);
      for (int i = 0; i < 6; i++) begin b.push_back(8'h55); c.push_back(1'b0); end
      b.push_back(8'hD5); c.push_back(1'b0);
      for (int k = 0; k < len; k++) begin b.push_back(8'((n + k) % 256)); c.push_back(1'b0); end
      b.push_back(8'hFD); c.push_back(1'b1);
      while ((b.size() % 8) != 0) begin b.push_back(8'h07); c.push_back(1'b1); end
      for (int i = 0; i < gap * 8; i++) begin b.push_back(8'h07); c.push_back(1'b1); end
    end
    for (int i = 0; i < b.size(); i += 8) begin
      w = 72'd0;
      for (int j = 0; j < 8; j++) begin
        w[8*j +: 8] = b[i+j];
        w[64+j]     = c[i+j];
      end
      exp_q.push_back(w);
    end
  endfunction

  // Index of the first differing word after leading idles, or -1 when the streams agree
  function automatic int stream_diff();
    int off;
    off = 0;
    while ((off < cap_q.size()) && (cap_q[off] == IDLE_WC)) off++;
    cap_off = off;
    for (int i = 0; i < exp_q.size(); i++) begin
      if ((off + i) >= cap_q.size()) begin
        mm_act = 72'd0; mm_exp = exp_q[i]; return i;
      end
      if (cap_q[off+i] !== exp_q[i]) begin
        mm_act = cap_q[off+i]; mm_exp = exp_q[i]; return i;
      end
    end
    if ((cap_q.size() - off) != exp_q.size()) begin
      mm_act = cap_q[off+exp_q.size()]; mm_exp = 72'd0; return exp_q.size();
    end
    return -1;
  endfunction

  task automatic launch(input int len, input int ip, input int cnt, input logic with_stop);
    @(posedge clk); #1;
    frame_len = 16'(len);
    ipg       = 8'(ip);
    frame_cnt = 16'(cnt);
    start     = 1'b1;
    stop      = with_stop;
    arm_req   = arm_req + 1;
    @(posedge clk); #1;
    start = 1'b0;
    stop  = 1'b0;
  endtask

  task automatic wait_done(input int budget, output logic ok);
    for (int i = 0; (i < budget) && !done_seen; i++) begin
      @(posedge clk); #1;
    end
    ok = done_seen;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if ((txd !== IDLE_W) || (txc !== 8'hFF)) begin
      tests_failed++; $display("FAIL reset_word: got %h/%h want %h/ff", txd, txc, IDLE_W);
    end
    tests_run++;
    if ({vld, busy, done} !== 3'b000) begin
      tests_failed++; $display("FAIL reset_flags: vld/busy/done got %b want 000", {vld, busy, done});
    end
    tests_run++;
    if (frames_sent !== 32'd0) begin
      tests_failed++; $display("FAIL reset_count: got %0d want 0", frames_sent);
    end
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_single_frame();
    logic ok;
    int   d0;
    int   r;
    d0 = done_total;
    build_expected(64, 1, 1);
    launch(64, 1, 1, 1'b0);
    tests_run++;
    if (busy !== 1'b1) begin tests_failed++; $display("FAIL single_busy: got %b want 1", busy); end
    wait_done(200, ok);
    exp_sent += 1;
    tests_run++;
    if (ok !== 1'b1) begin tests_failed++; $display("FAIL single_done: got %b want 1", ok); end
    r = stream_diff();
    tests_run++;
    if (r != -1) begin tests_failed++; $display("FAIL single_stream: word %0d got %h want %h", r, mm_act, mm_exp); end
    tests_run++;
    if ((cap_q.size() - cap_off) != 11) begin
      tests_failed++; $display("FAIL single_len: got %0d words want 11", cap_q.size() - cap_off);
    end
    tests_run++;
    if (cap_q[cap_off+9] !== {8'hFF, 64'h07070707070707FD}) begin
      tests_failed++; $display("FAIL single_term: got %h want ff07070707070707fd", cap_q[cap_off+9]);
    end
    tests_run++;
    if (frames_sent !== 32'(exp_sent)) begin
      tests_failed++; $display("FAIL single_count: got %0d want %0d", frames_sent, exp_sent);
    end
    tests_run++;
    if ((done_busy !== 1'b0) || ((done_total - d0) != 1)) begin
      tests_failed++; $display("FAIL single_done_pulse: busy_at_done %b pulses %0d want 0 1", done_busy, done_total - d0);
    end
  endtask

  task automatic test_partial_term();
    logic ok;
    int   r;
    build_expected(61, 2, 2);
    launch(61, 2, 2, 1'b0);
    wait_done(300, ok);
    exp_sent += 2;
    r = stream_diff();
    tests_run++;
    if ((ok !== 1'b1) || (r != -1)) begin
      tests_failed++; $display("FAIL partial_stream: done %b word %0d got %h want %h", ok, r, mm_act, mm_exp);
    end
    tests_run++;
    if (cap_q[cap_off+8] !== {8'hE0, 64'h0707FD3C3B3A3938}) begin
      tests_failed++; $display("FAIL partial_term: got %h want e00707fd3c3b3a3938", cap_q[cap_off+8]);
    end
    tests_run++;
    if (cap_q[cap_off+12][7:0] !== 8'h01) begin
      tests_failed++; $display("FAIL partial_frame1_byte0: got %h want 01", cap_q[cap_off+12][7:0]);
    end
    tests_run++;
    if (frames_sent !== 32'(exp_sent)) begin
      tests_failed++; $display("FAIL partial_count: got %0d want %0d", frames_sent, exp_sent);
    end
  endtask

  task automatic test_clamp();
    logic ok;
    int   r;
    build_expected(10, 1, 1);
    launch(10, 1, 1, 1'b0);
    wait_done(200, ok);
    exp_sent += 1;
    r = stream_diff();
    tests_run++;
    if ((ok !== 1'b1) || (r != -1)) begin
      tests_failed++; $display("FAIL clamp_min_stream: done %b word %0d got %h want %h", ok, r, mm_act, mm_exp);
    end
    tests_run++;
    if (cap_q[cap_off+6][71:64] !== 8'hC0) begin
      tests_failed++; $display("FAIL clamp_min_txc: got %h want c0", cap_q[cap_off+6][71:64]);
    end
    build_expected(20000, 0, 1);
    launch(20000, 0, 1, 1'b0);
    wait_done(3000, ok);
    exp_sent += 1;
    r = stream_diff();
    tests_run++;
    if ((ok !== 1'b1) || (r != -1)) begin
      tests_failed++; $display("FAIL clamp_max_stream: done %b word %0d got %h want %h", ok, r, mm_act, mm_exp);
    end
    tests_run++;
    if ((cap_q.size() - cap_off) != 1203) begin
      tests_failed++; $display("FAIL clamp_max_len: got %0d words want 1203", cap_q.size() - cap_off);
    end
  endtask

  task automatic test_stop_continuous();
    logic ok;
    logic hit;
    int   r;
    build_expected(200, 2, 4);
    launch(200, 2, 0, 1'b0);
    hit = 1'b0;
    for (int i = 0; (i < 4000) && !hit; i++) begin
      @(posedge clk); #1;
      hit = (starts_seen >= 4) && (last_txc == 8'h00);
    end
    tests_run++;
    if (hit !== 1'b1) begin tests_failed++; $display("FAIL stop_reach_frame3: got %b want 1", hit); end
    stop = 1'b1;
    @(posedge clk); #1;
    stop = 1'b0;
    wait_done(400, ok);
    exp_sent += 4;
    r = stream_diff();
    tests_run++;
    if ((ok !== 1'b1) || (r != -1)) begin
      tests_failed++; $display("FAIL stop_stream: done %b word %0d got %h want %h", ok, r, mm_act, mm_exp);
    end
    tests_run++;
    if ((frames_sent !== 32'(exp_sent)) || (busy !== 1'b0)) begin
      tests_failed++; $display("FAIL stop_count: got %0d busy %b want %0d busy 0", frames_sent, busy, exp_sent);
    end
  endtask

  task automatic test_ipg_zero_restart();
    logic ok;
    logic hit;
    int   r;
    build_expected(50, 0, 3);
    launch(50, 0, 3, 1'b0);
    hit = 1'b0;
    for (int i = 0; (i < 1000) && !hit; i++) begin
      @(posedge clk); #1;
      hit = (starts_seen >= 2);
    end
    frame_len = 16'd300;
    ipg       = 8'd9;
    frame_cnt = 16'd0;
    start     = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(600, ok);
    exp_sent += 3;
    r = stream_diff();
    tests_run++;
    if ((ok !== 1'b1) || (r != -1)) begin
      tests_failed++; $display("FAIL ipg0_stream: done %b word %0d got %h want %h", ok, r, mm_act, mm_exp);
    end
    tests_run++;
    if (frames_sent !== 32'(exp_sent)) begin
      tests_failed++; $display("FAIL ipg0_count: got %0d want %0d", frames_sent, exp_sent);
    end
  endtask

  task automatic test_start_stop_same();
    logic ok;
    int   r;
    build_expected(80, 3, 1);
    launch(80, 3, 5, 1'b1);
    wait_done(300, ok);
    exp_sent += 1;
    r = stream_diff();
    tests_run++;
    if ((ok !== 1'b1) || (r != -1)) begin
      tests_failed++; $display("FAIL startstop_stream: done %b word %0d got %h want %h", ok, r, mm_act, mm_exp);
    end
  endtask

  task automatic test_random();
    logic ok;
    int   r;
    int   len;
    int   ip;
    int   cnt;
    for (int it = 0; it < 5; it++) begin
      len = $urandom_range(260, 30);
      ip  = $urandom_range(5, 0);
      cnt = $urandom_range(3, 1);
      build_expected(len, ip, cnt);
      launch(len, ip, cnt, 1'b0);
      wait_done(2000, ok);
      exp_sent += cnt;
      r = stream_diff();
      tests_run++;
      if ((ok !== 1'b1) || (r != -1)) begin
        tests_failed++;
        $display("FAIL random_stream len=%0d ipg=%0d cnt=%0d: done %b word %0d got %h want %h", len, ip, cnt, ok, r, mm_act, mm_exp);
      end
      tests_run++;
      if (frames_sent !== 32'(exp_sent)) begin
        tests_failed++; $display("FAIL random_count: got %0d want %0d", frames_sent, exp_sent);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    logic hit;
    int   bad;
    launch(300, 1, 0, 1'b0);
    hit = 1'b0;
    for (int i = 0; (i < 500) && !hit; i++) begin
      @(posedge clk); #1;
      hit = (starts_seen >= 1) && (last_txc == 8'h00);
    end
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    exp_sent = 0;
    tests_run++;
    if ((txd !== IDLE_W) || (txc !== 8'hFF) || ({vld, busy, done} !== 3'b000)) begin
      tests_failed++; $display("FAIL midreset_outputs: got %h/%h flags %b want %h/ff 000", txd, txc, {vld, busy, done}, IDLE_W);
    end
    tests_run++;
    if (frames_sent !== 32'd0) begin
      tests_failed++; $display("FAIL midreset_count: got %0d want 0", frames_sent);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    arm_req = arm_req + 1;
    repeat (40) @(posedge clk);
    #1;
    bad = 0;
    foreach (cap_q[i]) if (cap_q[i] !== IDLE_WC) bad++;
    tests_run++;
    if ((bad != 0) || (cap_q.size() < 15)) begin
      tests_failed++; $display("FAIL midreset_no_term: non-idle words %0d of %0d want 0", bad, cap_q.size());
    end
    tests_run++;
    if ((frames_sent !== 32'd0) || (busy !== 1'b0)) begin
      tests_failed++; $display("FAIL midreset_after: count %0d busy %b want 0 0", frames_sent, busy);
    end
  endtask

  task automatic test_vld_hold();
    tests_run++;
    if (vld_err != 0) begin tests_failed++; $display("FAIL vld_alternate: errors %0d want 0", vld_err); end
    tests_run++;
    if (hold_err != 0) begin tests_failed++; $display("FAIL txd_hold: errors %0d want 0", hold_err); end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_partial_term();
    test_clamp();
    test_stop_continuous();
    test_ipg_zero_restart();
    test_start_stop_same();
    test_random();
    test_reset_mid_frame();
    test_vld_hold();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
